// File: rtl/reg_file_pkg.sv
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared defaults and width helper for the multi-port reg file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package reg_file_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;

  // Width able to hold 0..2**addr_w busy registers inclusive.
  function automatic int busy_cnt_w(input int addr_w);
    return $clog2((1 << addr_w) + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_scoreboard.sv
// ============================================================================
// Module      : reg_scoreboard
// Description : Busy vector with reserve-over-clear priority and busy count.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 0,
  parameter int DEPTH    = 2 ** ADDR_W,
  parameter int CNT_W    = busy_cnt_w(ADDR_W)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              RESV,
  input  logic [ADDR_W-1:0] RESVADDR,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WADDR0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WADDR1,
  output logic [DEPTH-1:0]  busy_o,
  output logic [CNT_W-1:0]  busy_cnt_o
);

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             set_w, inc_w, clr0_w, clr1_w;

  always_comb begin
    set_w = RESV && !((ZERO_REG != 0) && (RESVADDR == '0));

    busy_d = busy_q;
    if (WE0) busy_d[WADDR0] = 1'b0;
    if (WE1) busy_d[WADDR1] = 1'b0;
    // Reserve is applied last: a new producer supersedes the one writing back.
    if (set_w) busy_d[RESVADDR] = 1'b1;

    inc_w  = set_w && !busy_q[RESVADDR];
    clr0_w = WE0 && busy_q[WADDR0] && !(set_w && (RESVADDR == WADDR0));
    clr1_w = WE1 && busy_q[WADDR1] && !(set_w && (RESVADDR == WADDR1))
             && !(WE0 && (WADDR0 == WADDR1));

    cnt_d = cnt_q + CNT_W'(inc_w) - CNT_W'(clr0_w) - CNT_W'(clr1_w);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// ============================================================================
// Module      : reg_file_mp
// Description : Two-write / two-read register file with bypass and scoreboard.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] WADDR0,
  input  logic [DATA_W-1:0] WDATA0,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] WADDR1,
  input  logic [DATA_W-1:0] WDATA1,
  input  logic [ADDR_W-1:0] RADDR1,
  input  logic [ADDR_W-1:0] RADDR2,
  output logic [DATA_W-1:0] RDATA1,
  output logic [DATA_W-1:0] RDATA2,
  input  logic              RESV,
  input  logic [ADDR_W-1:0] RESVADDR,
  output logic              BUSY1,
  output logic              BUSY2,
  output logic [ADDR_W:0]   BUSY_CNT
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = busy_cnt_w(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_w;
  logic [CNT_W-1:0]  cnt_w;
  logic              wr0_ok_w, wr1_ok_w;

  assign wr0_ok_w = WE0 && !((ZERO_REG != 0) && (WADDR0 == '0));
  assign wr1_ok_w = WE1 && !((ZERO_REG != 0) && (WADDR1 == '0));

  // Port 1 is assigned second so it wins on an address collision.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr0_ok_w) mem_q[WADDR0] <= WDATA0;
      if (wr1_ok_w) mem_q[WADDR1] <= WDATA1;
    end
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .DEPTH    (DEPTH),
    .CNT_W    (CNT_W)
  ) u_scoreboard (
    .CLK        (CLK),
    .RESET      (RESET),
    .RESV       (RESV),
    .RESVADDR   (RESVADDR),
    .WE0        (WE0),
    .WADDR0     (WADDR0),
    .WE1        (WE1),
    .WADDR1     (WADDR1),
    .busy_o     (busy_w),
    .busy_cnt_o (cnt_w)
  );

  assign BUSY_CNT = cnt_w;

  logic [ADDR_W-1:0] raddr_w [2];
  logic [DATA_W-1:0] rdata_w [2];
  logic              rbusy_w [2];

  assign raddr_w[0] = RADDR1;
  assign raddr_w[1] = RADDR2;

  generate
    for (genvar g = 0; g < 2; g++) begin : g_rd
      logic hit0_w, hit1_w, resv_hit_w;

      assign hit0_w     = (BYPASS != 0) && WE0 && (WADDR0 == raddr_w[g]);
      assign hit1_w     = (BYPASS != 0) && WE1 && (WADDR1 == raddr_w[g]);
      assign resv_hit_w = RESV && (RESVADDR == raddr_w[g]);

      always_comb begin
        if ((ZERO_REG != 0) && (raddr_w[g] == '0)) rdata_w[g] = '0;
        else if (hit1_w)                            rdata_w[g] = WDATA1;
        else if (hit0_w)                            rdata_w[g] = WDATA0;
        else                                        rdata_w[g] = mem_q[raddr_w[g]];

        rbusy_w[g] = busy_w[raddr_w[g]];
        if ((hit0_w || hit1_w) && !resv_hit_w) rbusy_w[g] = 1'b0;
      end
    end
  endgenerate

  assign RDATA1 = rdata_w[0];
  assign RDATA2 = rdata_w[1];
  assign BUSY1  = rbusy_w[0];
  assign BUSY2  = rbusy_w[1];

endmodule

`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the next-generation CPU datapath. It provides two synchronous write ports, two combinational read ports and optional write-to-read bypass. An integrated busy scoreboard lets the control unit stall on registers whose pending results have not yet been written back. It sits between the instruction decoder/ALU and the writeback stage, and generalises the 8x8 single-write register file.

## Interface
- `DATA_W`, 8: register width in bits.
- `ADDR_W`, 3: address width; depth `DEPTH = 2**ADDR_W`.
- `BYPASS`, 1: 1 makes a same-cycle write visible on the read ports; 0 means reads return stored contents only.
- `ZERO_REG`, 0: 1 makes register 0 hard-wired zero; writes and reserves to it are ignored and it is never busy.
- `CLK`  in  1  clock; all state updates on posedge.
- `RESET`  in  1  synchronous, active-high reset.
- `WE0`  in  1  write enable, port 0 (ALU result).
- `WADDR0`  in  `ADDR_W`  write address, port 0.
- `WDATA0`  in  `DATA_W`  write data, port 0.
- `WE1`  in  1  write enable, port 1 (load/writeback result; higher priority).
- `WADDR1`  in  `ADDR_W`  write address, port 1.
- `WDATA1`  in  `DATA_W`  write data, port 1.
- `RADDR1`, `RADDR2`  in  `ADDR_W`  read addresses.
- `RDATA1`, `RDATA2`  out  `DATA_W`  read data.
- `RESV`  in  1  reserve strobe: mark `RESVADDR` busy.
- `RESVADDR`  in  `ADDR_W`  register being reserved.
- `BUSY1`, `BUSY2`  out  1  busy flag of `RADDR1` / `RADDR2`.
- `BUSY_CNT`  out  `ADDR_W+1`  number of busy registers.

## Operation
- **Reset.** On a posedge with `RESET=1`, all registers, busy bits and `BUSY_CNT` become 0. `RESET` overrides all writes and reserves in that cycle.
- **Writes.**
  - With `WEn=1`, `WDATAn` is stored to `WADDRn` on the posedge.
  - If both ports write the same address, port 1 wins and the port 0 data is discarded.
  - Different addresses are both written in the same cycle.
- **Reads** are combinational from `RADDRx`.
  - With `BYPASS=1`, if `WE1` and `WADDR1==RADDRx`, the read returns `WDATA1`.
  - Otherwise, if `WE0` and `WADDR0==RADDRx`, it returns `WDATA0`.
  - Otherwise it returns the stored value.
- **Zero register.** With `ZERO_REG=1`, `RADDRx==0` reads 0 regardless of bypass.
- **Scoreboard.**
  - `RESV` sets `busy[RESVADDR]`.
  - A write on either port clears `busy[WADDRn]`.
  - If a reserve and a write target the same address in the same cycle, the reserve wins and the register stays busy (a new producer supersedes the old one). The written data is still stored.
  - Reserving an already-busy register leaves `BUSY_CNT` unchanged.
  - Writing a non-busy register leaves `BUSY_CNT` unchanged.
- **Busy outputs.**
  - `BUSYx = busy[RADDRx]`.
  - With `BYPASS=1`, `BUSYx` is forced 0 when a same-cycle write to `RADDRx` is forwarded and that address is not simultaneously reserved.
- **`BUSY_CNT`** is registered. It is updated each posedge by +1 / 0 / -1 / -2 according to the net change in busy bits, with a range of 0..`DEPTH`.

## Timing
- Write latency is 1 cycle. A stored value is visible on the read ports in the cycle after the posedge.
- With `BYPASS=1`, a write is visible in the same cycle (combinational path from `WDATA` to `RDATA`).
- Busy bits take effect the cycle after the `RESV` posedge.
- `BUSY_CNT` is valid the cycle after any change.
- Reset values: `RDATA1`/`RDATA2` read 0, `BUSY1`/`BUSY2` are 0 and `BUSY_CNT` is 0 from the first cycle after the reset edge.
- Reset mid-operation: a pending write or reserve in the reset cycle is dropped.
- Read ports carry no delay annotations; delays belong to the testbench only.

## Structure
- Package `reg_file_pkg` holds the default `DATA_W`/`ADDR_W` localparams and a `clog2`-based width helper for `BUSY_CNT`.
- Sub-module `reg_scoreboard` holds the busy vector, reserve/clear priority and `BUSY_CNT`. Its inputs are `CLK`, `RESET`, the reserve port and both write-clear ports; its outputs are the busy vector and count.
- The top level holds the storage array, write-port priority, bypass muxes and the zero-register gating.

## Test plan
- Reset then read all addresses, with defaults: every read returns 0x00, `BUSY_CNT=0`.
- `WE0`: reg1←0x11, next cycle `WE1`: reg2←0x88; then `RADDR1=1`, `RADDR2=2` → `RDATA1=0x11`, `RDATA2=0x88`.
- Same cycle `WE0`: reg3←0xAA and `WE1`: reg3←0x55 → reg3 reads 0x55. With `BYPASS=1` and `RADDR1=3` in that cycle, `RDATA1=0x55`; with `BYPASS=0`, it shows the old value.
- `RESV` reg4 → `BUSY1=1` (`RADDR1=4`), `BUSY_CNT=1`. Next, `WE0`: reg4←0x7E → `BUSY1=0`, `BUSY_CNT=0`, reads 0x7E.
- `RESV` reg5 and `WE1` to reg5 in the same cycle → reg5 still busy, data stored, `BUSY_CNT=1`.
- `ZERO_REG=1`: write 0xFF to reg0 and `RESV` reg0 → reads 0, `BUSY1=0`. Then `RESET` during a write to reg6 → reg6 reads 0 and the count is 0.
